// File: rtl/phase_scheduler_if.sv
// phase_scheduler_if: offer/accept handshake and phase-complete pulse between scheduler (master) and light sequencer (slave)
interface phase_scheduler_if;
  logic       sel_valid;
  logic       sel_ready;
  logic [1:0] sel_road;
  logic [7:0] sel_green;
  logic       phase_done;
  modport master(output sel_valid, sel_road, sel_green, input sel_ready, phase_done);
  modport slave(input sel_valid, sel_road, sel_green, output sel_ready, phase_done);
endinterface

// File: rtl/phase_scheduler.sv
// phase_scheduler: density-weighted round-robin road arbiter with aging and emergency hold; clk/rst, veh/dens/emg_mode/er in, bus (offer handshake), emg_active/emg_road/starved out
module phase_scheduler #(
  parameter int BASE_GREEN = 20,
  parameter int DENS_STEP  = 10,
  parameter int MAX_GREEN  = 100,
  parameter int AGE_LIMIT  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          veh,
  input  logic [7:0]          dens,
  input  logic                emg_mode,
  input  logic [1:0]          er,
  phase_scheduler_if.master   bus,
  output logic                emg_active,
  output logic [1:0]          emg_road,
  output logic [3:0]          starved
);
  typedef enum logic [1:0] {IDLE, OFFER, ACTIVE, EMG} state_t;
  state_t state, state_n;
  logic [1:0] last_grant, lg_n, pick, best, r, road_n;
  logic [3:0][3:0] age, age_n;
  logic [3:0] starved_n;
  logic found, any_st, valid_n, xfer;
  logic [15:0] gsum;
  logic [7:0] green, green_n;
  always_comb begin
    pick = '0;
    best = '0;
    r = '0;
    found = 1'b0;
    any_st = |(veh & starved);
    for (int k = 0; k < 4; k++) begin
      r = last_grant + 2'(k + 1);
      if (veh[r] && (!any_st || starved[r]) && (!found || (!any_st && 2'(dens >> {r, 1'b0}) > best))) begin
        pick = r;
        best = 2'(dens >> {r, 1'b0});
        found = 1'b1;
      end
    end
    gsum = 16'(BASE_GREEN) + 16'(best) * 16'(DENS_STEP);
    green = gsum > 16'(MAX_GREEN) ? 8'(MAX_GREEN) : gsum[7:0];
  end
  always_comb begin
    state_n = state;
    valid_n = bus.sel_valid;
    road_n = bus.sel_road;
    green_n = bus.sel_green;
    lg_n = last_grant;
    xfer = 1'b0;
    if (emg_mode) begin
      state_n = EMG;
      valid_n = 1'b0;
    end else
      case (state)
        IDLE: if (|veh) begin
          state_n = OFFER;
          valid_n = 1'b1;
          road_n = pick;
          green_n = green;
        end
        OFFER: if (bus.sel_ready) begin
          state_n = ACTIVE;
          valid_n = 1'b0;
          lg_n = bus.sel_road;
          xfer = 1'b1;
        end
        ACTIVE: if (bus.phase_done) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    for (int i = 0; i < 4; i++) begin
      age_n[i] = emg_mode ? age[i] :
                 (!veh[i] || (xfer && bus.sel_road == 2'(i))) ? 4'd0 :
                 xfer ? age[i] + 4'(age[i] != 4'hf) : age[i];
      starved_n[i] = age_n[i] >= 4'(AGE_LIMIT);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bus.sel_valid <= 1'b0;
      bus.sel_road <= '0;
      bus.sel_green <= '0;
      last_grant <= 2'd3;
      age <= '0;
      starved <= '0;
      emg_active <= 1'b0;
      emg_road <= '0;
    end else begin
      state <= state_n;
      bus.sel_valid <= valid_n;
      bus.sel_road <= road_n;
      bus.sel_green <= green_n;
      last_grant <= lg_n;
      age <= age_n;
      starved <= starved_n;
      emg_active <= emg_mode;
      emg_road <= emg_mode ? er : emg_road;
    end
  end
endmodule

// File: tb/tb_phase_scheduler.sv
// tb_phase_scheduler: randomized and directed checks of phase_scheduler against a behavioural reference
module tb_phase_scheduler;
  localparam int BG = 20, DS = 10, MG = 45, AL = 3;
  logic clk = 0, rst = 1, emg_mode = 0;
  logic [3:0] veh = 0;
  logic [7:0] dens = 0;
  logic [1:0] er = 0;
  logic emg_active;
  logic [1:0] emg_road;
  logic [3:0] starved;
  int errors = 0, checks = 0;
  bit chk_en = 0;
  phase_scheduler_if bus();
  phase_scheduler #(.BASE_GREEN(BG), .DENS_STEP(DS), .MAX_GREEN(MG), .AGE_LIMIT(AL)) dut (
    .clk(clk), .rst(rst), .veh(veh), .dens(dens), .emg_mode(emg_mode), .er(er),
    .bus(bus), .emg_active(emg_active), .emg_road(emg_road), .starved(starved));
  always #5 clk = ~clk;

  int m_age[4];
  int m_lg = 3, m_road = 0, m_green = 0, m_er = 0;
  bit m_off = 0, m_act = 0, m_emg = 0;

  task automatic check(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int dens_of(int i);
    return int'((dens >> (2 * i)) & 8'h3);
  endfunction

  task automatic arbitrate();
    int q[$];
    int st[$];
    int dmax;
    for (int k = 1; k <= 4; k++)
      if (veh[(m_lg + k) % 4]) q.push_back((m_lg + k) % 4);
    foreach (q[j]) if (m_age[q[j]] >= AL) st.push_back(q[j]);
    if (st.size() > 0) m_road = st[0];
    else begin
      dmax = -1;
      foreach (q[j]) if (dens_of(q[j]) > dmax) dmax = dens_of(q[j]);
      foreach (q[j]) if (dens_of(q[j]) == dmax) begin m_road = q[j]; break; end
    end
    m_green = BG + dens_of(m_road) * DS;
    if (m_green > MG) m_green = MG;
  endtask

  task automatic model_step();
    bit acc;
    if (rst) begin
      foreach (m_age[i]) m_age[i] = 0;
      m_lg = 3; m_road = 0; m_green = 0; m_er = 0;
      m_off = 0; m_act = 0; m_emg = 0;
    end else if (emg_mode) begin
      m_emg = 1; m_off = 0; m_act = 0; m_er = int'(er);
    end else begin
      acc = m_off && bus.sel_ready;
      if (!m_emg && !m_off && !m_act && veh != 0) begin
        arbitrate();
        m_off = 1;
      end else if (m_emg) m_emg = 0;
      else if (acc) begin
        m_off = 0; m_act = 1; m_lg = m_road;
      end else if (m_act && bus.phase_done) m_act = 0;
      for (int i = 0; i < 4; i++)
        if (!veh[i] || (acc && i == m_lg)) m_age[i] = 0;
        else if (acc && m_age[i] < 15) m_age[i]++;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      int st;
      st = 0;
      for (int i = 0; i < 4; i++) if (m_age[i] >= AL) st |= (1 << i);
      check("sel_valid", int'(bus.sel_valid), int'(m_off));
      check("sel_road", int'(bus.sel_road), m_road);
      check("sel_green", int'(bus.sel_green), m_green);
      check("emg_active", int'(emg_active), int'(m_emg));
      check("emg_road", int'(emg_road), m_er);
      check("starved", int'(starved), st);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic grant(output int road);
    int n;
    n = 0;
    while (!bus.sel_valid && n < 10) begin tick(); n++; end
    check("grant_wait", int'(bus.sel_valid), 1);
    road = int'(bus.sel_road);
    bus.sel_ready = 1; tick();
    bus.sel_ready = 0; bus.phase_done = 1; tick();
    bus.phase_done = 0;
  endtask

  initial begin
    int r, exp_r[3], g0, r0;
    bus.sel_ready = 0;
    bus.phase_done = 0;
    rst = 1;
    tick();
    chk_en = 1;
    tick();
    check("rst_valid", int'(bus.sel_valid), 0);
    check("rst_green", int'(bus.sel_green), 0);
    check("rst_starved", int'(starved), 0);
    check("rst_emg", int'(emg_active), 0);
    rst = 0; veh = 4'b0001; dens = 8'h02;
    tick();
    check("s1_valid", int'(bus.sel_valid), 1);
    check("s1_road", int'(bus.sel_road), 0);
    check("s1_green", int'(bus.sel_green), 40);
    bus.sel_ready = 1; tick();
    check("s1_accept", int'(bus.sel_valid), 0);
    bus.sel_ready = 0; veh = 0; bus.phase_done = 1; tick();
    bus.phase_done = 0; tick();
    check("s1_idle", int'(bus.sel_valid), 0);

    do_reset();
    veh = 4'b1111; dens = 8'h7C;
    tick();
    check("s2_road", int'(bus.sel_road), 1);
    check("s2_green_clamp", int'(bus.sel_green), 45);
    bus.sel_ready = 1; tick();
    bus.sel_ready = 0; bus.phase_done = 1; tick();
    bus.phase_done = 0; tick();
    check("s2_valid2", int'(bus.sel_valid), 1);
    check("s2_road2", int'(bus.sel_road), 2);

    do_reset();
    veh = 4'b0111; dens = 8'h33;
    exp_r = '{0, 2, 0};
    for (int g = 0; g < 3; g++) begin
      grant(r);
      check("s3_rr", r, exp_r[g]);
    end
    check("s3_starved", int'(starved), 4'b0010);
    tick();
    check("s3_road", int'(bus.sel_road), 1);
    check("s3_green", int'(bus.sel_green), 20);
    bus.sel_ready = 1; tick();
    check("s3_unstarved", int'(starved[1]), 0);
    bus.sel_ready = 0; bus.phase_done = 1; tick();
    bus.phase_done = 0;

    do_reset();
    veh = 4'b0001; dens = 8'h01;
    tick();
    g0 = int'(bus.sel_green); r0 = int'(bus.sel_road);
    check("bp_green", g0, 30);
    for (int c = 0; c < 6; c++) begin
      veh = 4'($urandom); dens = 8'($urandom); tick();
      check("bp_hold_valid", int'(bus.sel_valid), 1);
      check("bp_hold_road", int'(bus.sel_road), r0);
      check("bp_hold_green", int'(bus.sel_green), g0);
    end
    bus.sel_ready = 1; tick();
    check("bp_xfer", int'(bus.sel_valid), 0);
    bus.sel_ready = 0;

    do_reset();
    veh = 4'b0011; dens = 8'h00;
    tick();
    check("em_offer", int'(bus.sel_valid), 1);
    emg_mode = 1; er = 2'b10; bus.sel_ready = 1; tick();
    check("em_valid", int'(bus.sel_valid), 0);
    check("em_active", int'(emg_active), 1);
    check("em_road", int'(emg_road), 2);
    bus.sel_ready = 0; tick();
    emg_mode = 0; tick();
    check("em_exit", int'(emg_active), 0);
    check("em_exit_valid", int'(bus.sel_valid), 0);
    tick();
    check("em_reoffer", int'(bus.sel_valid), 1);
    check("em_reoffer_road", int'(bus.sel_road), 0);
    emg_mode = 1; tick();
    rst = 1; tick();
    check("em_rst_active", int'(emg_active), 0);
    check("em_rst_road", int'(emg_road), 0);
    rst = 0; emg_mode = 0;

    for (int c = 0; c < 3000; c++) begin
      veh = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF ^ 4'(1 << $urandom_range(0, 4));
      dens = 8'($urandom);
      er = 2'($urandom);
      if ($urandom_range(0, 29) == 0) emg_mode = ~emg_mode;
      bus.sel_ready = 1'($urandom_range(0, 1));
      bus.phase_done = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/phase_scheduler.md
# phase_scheduler

Arbitration front-end for the intersection light sequencer. Each cycle it watches vehicle presence and 2-bit density for roads A–D and chooses which road gets the next green phase. The choice is density-weighted round-robin with per-road aging, so no waiting road is starved. It offers the chosen road and its computed green duration to the light sequencer over a valid/ready handshake, holds off until the sequencer reports the phase finished, and suspends arbitration while emergency mode is active.

## Interface
Parameters:
- BASE_GREEN, 20, minimum green duration in timer ticks
- DENS_STEP, 10, extra ticks per density unit
- MAX_GREEN, 100, green duration clamp (≤255)
- AGE_LIMIT, 8, age at which a waiting road becomes starved (1–15)

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous active-high reset
- veh  input  4  vehicle presence; bit0=A … bit3=D
- dens  input  8  packed densities; [1:0]=A, [3:2]=B, [5:4]=C, [7:6]=D
- emg_mode  input  1  emergency mode enable
- er  input  2  emergency road (00:A, 01:B, 10:C, 11:D)
- sel_valid  output  1  phase offer valid
- sel_ready  input  1  sequencer accepts offer
- sel_road  output  2  offered road index
- sel_green  output  8  offered green duration in ticks
- phase_done  input  1  one-cycle pulse from the sequencer when the accepted phase's yellow ends
- emg_active  output  1  scheduler is in EMG state
- emg_road  output  2  registered copy of er while in EMG
- starved  output  4  per-road flag, age ≥ AGE_LIMIT

## Operation
- State machine: IDLE, OFFER, ACTIVE, EMG. All outputs are registered.
- Reset values:
  - state = IDLE; sel_valid = 0, sel_road = 0, sel_green = 0
  - emg_active = 0, emg_road = 0, starved = 0
  - all ages = 0; last_grant = 3, so road A wins the first tie
- emg_mode = 1 in any state: next state is EMG.
  - sel_valid drops and any pending offer is discarded; an accepted phase is forgotten.
  - emg_active = 1 and emg_road = er, updated every cycle in EMG.
  - Ages are frozen.
- In EMG, when emg_mode = 0: next state is IDLE and emg_active = 0.
- IDLE, veh ≠ 0, emg_mode = 0:
  - Arbitrate on the current veh, dens and ages.
  - Register sel_road and sel_green, set sel_valid = 1, move to OFFER.
- IDLE with veh = 0: stay in IDLE.
- Arbitration, among roads with veh = 1:
  - If any requesting road is starved, pick the first starved road in round-robin order from last_grant+1.
  - Otherwise pick the road with the highest density; ties go to the first in round-robin order from last_grant+1.
- Green duration: sel_green = min(BASE_GREEN + dens_r·DENS_STEP, MAX_GREEN).
  - The sum is computed at ≥10 bits before the clamp, so there is no 8-bit wrap.
- OFFER:
  - sel_valid, sel_road and sel_green are held stable until accepted, even if veh for that road drops.
  - On sel_valid & sel_ready: go to ACTIVE, sel_valid = 0, last_grant = sel_road.
- Aging, applied at the accept edge:
  - The granted road's age goes to 0.
  - Every other road with veh = 1 gets age+1, saturating at 15.
- Aging, any cycle: a road with veh = 0 has its age cleared to 0.
  - This clear takes precedence over an increment in the same cycle.
- starved[i] = (age[i] ≥ AGE_LIMIT), registered alongside the ages.
- ACTIVE: phase_done moves to IDLE. phase_done is ignored in every other state.
- sel_ready outside OFFER is ignored.

## Timing
- Request to offer: veh sampled in an IDLE cycle gives sel_valid = 1 on the next edge (1-cycle latency).
- Handshake:
  - A transfer occurs in a cycle where sel_valid and sel_ready are both high.
  - sel_valid is low in the following cycle.
  - sel_valid never deasserts without a transfer, except on emergency or reset.
- Phase turnaround: phase_done in ACTIVE at cycle n gives IDLE at n+1 and sel_valid at n+2 if requests are pending.
- emg_mode rising at cycle n: emg_active = 1 and sel_valid = 0 from n+1.
- emg_mode falling at cycle n: IDLE at n+1; a new offer is possible at n+2.
- rst sampled high at any edge, including mid-OFFER or mid-ACTIVE: all state returns to reset values at that edge. rst overrides emg_mode.
- Simultaneous emg_mode and sel_ready in OFFER: emergency wins. No transfer occurs and ages are unchanged.

## Test plan
- Reset, then veh = 0001, dens A = 2:
  - sel_valid rises 1 cycle later with road 0, green 40.
  - sel_ready = 1 gives ACTIVE; phase_done returns to IDLE.
- veh = 1111, dens = {D=1, C=3, B=3, A=0}, last_grant = 3:
  - The offer is road 1 (B) with green 50.
  - After accept and phase_done, the next offer is road 2 (C); the tie is broken round-robin.
- Starvation, with AGE_LIMIT = 3, veh = 0111, dens A = C = 3, B = 0:
  - After 3 grants alternating A and C, starved[1] = 1.
  - The next offer is road 1 with green 20, after which B's age returns to 0.
- Clamp, with MAX_GREEN = 35 and dens = 2: sel_green = 35, not 40.
- Backpressure: hold sel_ready = 0 for 6 cycles while veh and dens change.
  - sel_valid, sel_road and sel_green stay constant.
  - The transfer occurs only on the cycle sel_ready rises.
- Emergency in OFFER, with er = 10:
  - Next cycle sel_valid = 0, emg_active = 1, emg_road = 2, ages unchanged.
  - After emg_mode drops, a fresh offer appears 2 cycles later.
  - Asserting rst mid-EMG clears everything at the next edge.
